// File: rtl/ifetch_unit.sv
// Instruction fetch unit: sequential PC, 2-entry {inst, pc} buffer toward decode, redirect support.
// Optional backpressure counter compiled in with macro IFETCH_STALL_CNT_EN.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] stall_cycles
);

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  logic [31:0] r_fetch_pc;
  logic [1:0]  r_count;
  logic        r_wr_ptr;
  logic        r_rd_ptr;
  logic [31:0] r_mem_inst [2];
  logic [31:0] r_mem_pc   [2];

  logic        w_pop;
  logic        w_push;
  logic [1:0]  w_count_next;
  logic        w_unused_bits;

  assign inst_valid = (r_count != 2'd0);
  assign w_pop      = inst_valid && inst_ready;
  assign w_push     = !redirect_valid && ((r_count != 2'd2) || w_pop);
  assign w_count_next = r_count + {1'b0, w_push} - {1'b0, w_pop};

  assign imem_addr  = {r_fetch_pc[31:2], 2'b00};
  // Head is gated so an empty buffer (including reset) presents zeros.
  assign inst       = inst_valid ? r_mem_inst[r_rd_ptr] : 32'h0;
  assign inst_pc    = inst_valid ? r_mem_pc[r_rd_ptr]   : 32'h0;

  assign w_unused_bits = ^{redirect_pc[1:0], r_fetch_pc[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC_ALIGNED;
      r_count    <= 2'd0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
    end else if (redirect_valid) begin
      r_fetch_pc <= {redirect_pc[31:2], 2'b00};
      r_count    <= 2'd0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
    end else begin
      r_count <= w_count_next;
      if (w_push) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
        r_wr_ptr   <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
    end
  end

  // Storage needs no reset: entries are only observable through r_count.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (w_push && (r_wr_ptr == gi[0])) begin
          r_mem_inst[gi] <= imem_data;
          r_mem_pc[gi]   <= r_fetch_pc;
        end
      end
    end
  endgenerate

`ifdef IFETCH_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= 32'h0;
    end else if (inst_valid && !inst_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cnt;
`else
  assign stall_cycles = 32'h0;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed vector table, hand sequences, and a
// randomized run against a queue-based reference model.
module tb_ifetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] stall_cycles;

  int n_assert = 0;
  int n_fail = 0;
  bit rom_mode = 1'b0;

  ifetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .imem_addr(imem_addr),
    .imem_data(imem_data),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .inst(inst),
    .inst_pc(inst_pc),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  // Mode 0: word index + 1 (ROM 1,2,3,4...). Mode 1: scrambled contents.
  function automatic logic [31:0] rom_word(input bit mode, input logic [31:0] a);
    if (mode) return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    return (a >> 2) + 32'd1;
  endfunction

  always_comb imem_data = rom_word(rom_mode, imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue of {inst, pc}, fetch address, stall count.
  typedef struct { logic [31:0] inst; logic [31:0] pc; } entry_t;
  entry_t      q[$];
  logic [31:0] m_pc;
  logic [31:0] m_stall;

  function automatic logic [31:0] exp_stall(input logic [31:0] n);
`ifdef IFETCH_STALL_CNT_EN
    return n;
`else
    return 32'h0;
`endif
  endfunction

  task automatic model_reset();
    q.delete();
    m_pc = RST_PC & 32'hFFFF_FFFC;
    m_stall = 32'h0;
  endtask

  task automatic model_check();
    chk("m_valid", {31'h0, inst_valid}, {31'h0, q.size() != 0});
    if (q.size() != 0) begin
      chk("m_inst", inst, q[0].inst);
      chk("m_inst_pc", inst_pc, q[0].pc);
    end
    chk("m_imem_addr", imem_addr, m_pc);
    chk("m_stall", stall_cycles, exp_stall(m_stall));
  endtask

  task automatic model_advance();
    bit v;
    entry_t e;
    v = (q.size() != 0);
    if (v && !inst_ready && m_stall != 32'hFFFF_FFFF) m_stall++;
    if (redirect_valid) begin
      q.delete();
      m_pc = redirect_pc & 32'hFFFF_FFFC;
    end else begin
      if (v && inst_ready) void'(q.pop_front());
      if (q.size() < 2) begin
        e.inst = rom_word(rom_mode, m_pc);
        e.pc = m_pc;
        q.push_back(e);
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    #1;
    chk("rst_valid", {31'h0, inst_valid}, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_imem_addr", imem_addr, RST_PC);
    chk("rst_stall", stall_cycles, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        ready;
    logic        redir;
    logic [31:0] rpc;
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] addr;
  } vec_t;

  vec_t tbl[13];

  initial begin
    // Stall from reset for 5 cycles, drain, then redirect while full.
    tbl[0]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'd0,  32'h0,  32'h0};
    tbl[1]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'd1,  32'h0,  32'h4};
    tbl[2]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'd1,  32'h0,  32'h8};
    tbl[3]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'd1,  32'h0,  32'h8};
    tbl[4]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'd1,  32'h0,  32'h8};
    tbl[5]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'd1,  32'h0,  32'h8};
    tbl[6]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'd2,  32'h4,  32'hC};
    tbl[7]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'd3,  32'h8,  32'h10};
    tbl[8]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'd4,  32'hC,  32'h14};
    tbl[9]  = '{1'b0, 1'b1, 32'h41, 1'b1, 32'd5,  32'h10, 32'h18};
    tbl[10] = '{1'b1, 1'b0, 32'h0,  1'b0, 32'd0,  32'h0,  32'h40};
    tbl[11] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'd17, 32'h40, 32'h44};
    tbl[12] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'd18, 32'h44, 32'h48};

    rom_mode = 1'b0;
    apply_reset();
    for (int i = 0; i < 13; i++) begin
      inst_ready = tbl[i].ready;
      redirect_valid = tbl[i].redir;
      redirect_pc = tbl[i].rpc;
      #1;
      chk($sformatf("tbl%0d_valid", i), {31'h0, inst_valid}, {31'h0, tbl[i].valid});
      if (tbl[i].valid) begin
        chk($sformatf("tbl%0d_inst", i), inst, tbl[i].inst);
        chk($sformatf("tbl%0d_inst_pc", i), inst_pc, tbl[i].pc);
      end
      chk($sformatf("tbl%0d_imem_addr", i), imem_addr, tbl[i].addr);
      step();
    end

    // Address wrap at the top of the address space.
    inst_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    #1;
    chk("wrap_valid0", {31'h0, inst_valid}, 32'h0);
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    step();
    #1;
    chk("wrap_valid1", {31'h0, inst_valid}, 32'h1);
    chk("wrap_pc1", inst_pc, 32'hFFFF_FFFC);
    chk("wrap_inst1", inst, 32'h4000_0000);
    chk("wrap_addr1", imem_addr, 32'h0);
    step();
    #1;
    chk("wrap_pc2", inst_pc, 32'h0);
    chk("wrap_inst2", inst, 32'h1);
    inst_ready = 1'b0;
    step();
    step();

    // Asynchronous reset in mid-cycle with a full buffer.
    #1;
    chk("prerst_valid", {31'h0, inst_valid}, 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_valid", {31'h0, inst_valid}, 32'h0);
    chk("async_addr", imem_addr, RST_PC);
    chk("async_inst", inst, 32'h0);
    chk("async_inst_pc", inst_pc, 32'h0);
    chk("async_stall", stall_cycles, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    inst_ready = 1'b0;
    for (int i = 0; i < 9; i++) step();
    #1;
    chk("stall_cnt", stall_cycles, exp_stall(32'd8));
    chk("stall_inst", inst, 32'd1);
    chk("stall_inst_pc", inst_pc, 32'h0);
    chk("stall_addr", imem_addr, 32'h8);
    inst_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("drain%0d_valid", i), {31'h0, inst_valid}, 32'h1);
      chk($sformatf("drain%0d_inst", i), inst, i + 1);
      step();
    end

    // Randomized run against the reference model.
    rom_mode = 1'b1;
    apply_reset();
    model_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      inst_ready = ($urandom_range(0, 99) < 65);
      redirect_valid = ($urandom_range(0, 99) < 7);
      if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF0 + $urandom_range(0, 15);
      else redirect_pc = $urandom;
      #1;
      model_check();
      if ($urandom_range(0, 199) == 0) begin
        #1;
        rst_n = 1'b0;
        #1;
        chk("rnd_rst_valid", {31'h0, inst_valid}, 32'h0);
        chk("rnd_rst_addr", imem_addr, RST_PC);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        model_advance();
        step();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 imem_addr  output  32  byte address to instruction ROM, driven directly from the fetch_pc register.
REQ-005 imem_data  input  32  ROM word for imem_addr, valid combinationally in the same cycle.
REQ-006 redirect_valid  input  1  one-cycle request to restart fetch at redirect_pc (branch/jump).
REQ-007 redirect_pc  input  32  new fetch byte address.
REQ-008 inst_valid  output  1  buffer head holds a valid instruction.
REQ-009 inst_ready  input  1  decode accepts the head this cycle.
REQ-010 inst  output  32  instruction word at the buffer head.
REQ-011 inst_pc  output  32  byte address of inst.
REQ-012 stall_cycles  output  32  backpressure counter (see Configuration).

Function
REQ-013 The block SHALL hold fetch_pc (32 bits) and a 2-entry FIFO of {instruction, pc} pairs with a 2-bit occupancy count (0..2).
REQ-014 imem_addr SHALL equal fetch_pc with bits [1:0] forced to 0.
REQ-015 pop SHALL occur when inst_valid && inst_ready; inst_valid SHALL equal (count != 0).
REQ-016 push SHALL occur when redirect_valid == 0 and (count < 2 or pop); it writes {imem_data, fetch_pc} and fetch_pc advances by 4 (modulo 2^32, wraps 32'hFFFF_FFFC -> 0).
REQ-017 Simultaneous push and pop at count 2 or 1 SHALL leave count unchanged with FIFO order preserved.
REQ-018 When full and no pop: no push, fetch_pc and imem_addr held.
REQ-019 Latency: a word fetched at cycle N SHALL be presented on inst at cycle N+1 when the FIFO was empty.
REQ-020 redirect_valid SHALL take priority over push and pop: FIFO flushed (count = 0), fetch_pc <= {redirect_pc[31:2], 2'b00}, inst_valid low next cycle; a handshake on that cycle is still counted as consumed by decode but the entry is discarded.
REQ-021 First instruction from the redirect target SHALL appear on inst two cycles after the redirect cycle.
REQ-022 inst and inst_pc SHALL be stable while inst_valid && !inst_ready and no redirect.
REQ-023 Back-to-back redirects SHALL each override the previous; only the last target is fetched.

Reset
REQ-024 On rst_n low, immediately and asynchronously: fetch_pc = RESET_PC with bits [1:0] = 0, count = 0, FIFO pointers = 0, stall_cycles = 0.
REQ-025 During reset inst_valid = 0, inst = 0, inst_pc = 0, imem_addr = RESET_PC.
REQ-026 Reset asserted mid-operation SHALL discard all buffered instructions; first fetch after release is at RESET_PC on the first rising edge with rst_n high.

Configuration
REQ-027 Macro IFETCH_STALL_CNT_EN SHALL compile in the backpressure counter.
REQ-028 With IFETCH_STALL_CNT_EN defined, stall_cycles SHALL increment by 1 each cycle with inst_valid && !inst_ready, saturating at 32'hFFFF_FFFF, unaffected by redirect.
REQ-029 Without IFETCH_STALL_CNT_EN, stall_cycles SHALL be constant 0 and no counter register SHALL exist.

Verification
REQ-030 Reset release, RESET_PC=0, inst_ready=1, ROM words 1,2,3,4 -> inst sequence 1,2,3,4 with inst_pc 0,4,8,12, one per cycle starting cycle 1.
REQ-031 inst_ready=0 for 5 cycles from reset -> count reaches 2, imem_addr holds 32'h8, inst stays 1/pc 0; on release outputs 1,2,3 consecutively with no gap.
REQ-032 redirect_valid with redirect_pc=32'h0000_0041 while FIFO full -> next cycle inst_valid=0, imem_addr=32'h40; following cycle inst_pc=32'h40.
REQ-033 fetch_pc at 32'hFFFF_FFFC, inst_ready=1 -> inst_pc 32'hFFFF_FFFC followed by 32'h0.
REQ-034 rst_n pulsed low mid-stream with FIFO holding 2 entries -> inst_valid drops immediately, imem_addr = RESET_PC, restart from RESET_PC.
REQ-035 With IFETCH_STALL_CNT_EN, inst_ready=0 for 7 cycles after FIFO fills -> stall_cycles = count of cycles inst_valid was high (8 including first valid cycle); without macro stays 0.
